// File: rtl/spike_pulse_stretch.sv
// spike_pulse_stretch: per-channel spike-to-pulse stretcher
// with programmable length, retrigger mode and sticky drop flags.
module spike_pulse_stretch #(
  parameter int NCH  = 4,
  parameter int WRES = 3
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic [NCH-1:0]  in,
  input  logic [WRES-1:0] len,
  input  logic            retrig,
  input  logic            clr_drop,
  output logic [NCH-1:0]  out,
  output logic [NCH-1:0]  busy,
  output logic [NCH-1:0]  done,
  output logic [NCH-1:0]  drop
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t          state     [NCH];
  state_t          state_nxt [NCH];
  logic [WRES-1:0] rem       [NCH];
  logic [WRES-1:0] rem_nxt   [NCH];
  logic [NCH-1:0]  drop_set;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= IDLE;
        rem[i]   <= '0;
      end
      drop <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= state_nxt[i];
        rem[i]   <= rem_nxt[i];
      end
      // a drop in the same cycle as the clear keeps the flag set
      drop <= (drop & ~{NCH{clr_drop}}) | drop_set;
    end
  end

  always_comb begin
    out      = '0;
    busy     = '0;
    done     = '0;
    drop_set = '0;
    for (int i = 0; i < NCH; i++) begin
      state_nxt[i] = state[i];
      rem_nxt[i]   = rem[i];
      unique case (state[i])
        IDLE: begin
          out[i] = in[i];
          if (in[i]) begin
            if (len != '0) begin
              rem_nxt[i]   = len;
              state_nxt[i] = ACTIVE;
            end else begin
              done[i] = 1'b1;
            end
          end
        end
        ACTIVE: begin
          out[i]  = 1'b1;
          busy[i] = 1'b1;
          if (in[i] && retrig) begin
            rem_nxt[i] = len;
            if (len == '0) begin
              done[i]      = 1'b1;
              state_nxt[i] = IDLE;
            end
          end else begin
            drop_set[i] = in[i];
            // rem is never below 1 here; treat <=1 as last cycle
            if (rem[i] > WRES'(1)) begin
              rem_nxt[i] = rem[i] - WRES'(1);
            end else begin
              rem_nxt[i]   = '0;
              done[i]      = 1'b1;
              state_nxt[i] = IDLE;
            end
          end
        end
      endcase
    end
    if (!rstb) begin
      out  = '0;
      busy = '0;
      done = '0;
    end
  end

endmodule

// File: tb/tb_spike_pulse_stretch.sv
// Directed bench for spike_pulse_stretch (NCH=4, WRES=3).
// Inputs change 1ns after posedge; outputs are checked at negedge.
module tb_spike_pulse_stretch;

  logic       clk = 1'b0;
  logic       rstb;
  logic [3:0] in;
  logic [2:0] len;
  logic       retrig;
  logic       clr_drop;
  logic [3:0] out;
  logic [3:0] busy;
  logic [3:0] done;
  logic [3:0] drop;

  int total = 0;
  int bad   = 0;

  spike_pulse_stretch #(
    .NCH (4),
    .WRES(3)
  ) dut (
    .clk     (clk),
    .rstb    (rstb),
    .in      (in),
    .len     (len),
    .retrig  (retrig),
    .clr_drop(clr_drop),
    .out     (out),
    .busy    (busy),
    .done    (done),
    .drop    (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c,
                     input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s c=%0d observed=%b expected=%b", tag, c, obs, exp);
    end
  endtask

  task automatic cycle(input string tag, input int c,
                       input logic [3:0] i,
                       input logic [3:0] eo, input logic [3:0] eb,
                       input logic [3:0] ed, input logic [3:0] edr);
    in = i;
    @(negedge clk);
    chk({tag, ".out"},  c, out,  eo);
    chk({tag, ".busy"}, c, busy, eb);
    chk({tag, ".done"}, c, done, ed);
    chk({tag, ".drop"}, c, drop, edr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstb     = 1'b0;
    in       = '0;
    len      = 3'd7;
    retrig   = 1'b0;
    clr_drop = 1'b0;

    // outputs forced low under reset even with spikes present
    for (int c = 0; c < 2; c++)
      cycle("reset", c, 4'b1111, 4'b0, 4'b0, 4'b0, 4'b0);
    rstb = 1'b1;

    // len=7: out 10..17, busy 11..17, done 17
    len = 3'd7;
    for (int c = 0; c < 20; c++)
      cycle("basic", c, (c == 10) ? 4'b0001 : 4'b0,
            (c >= 10 && c <= 17) ? 4'b0001 : 4'b0,
            (c >= 11 && c <= 17) ? 4'b0001 : 4'b0,
            (c == 17) ? 4'b0001 : 4'b0, 4'b0);

    // len=0: single-cycle pulses, never busy
    len = 3'd0;
    for (int c = 0; c < 10; c++)
      cycle("zero", c, (c == 5 || c == 6) ? 4'b0010 : 4'b0,
            (c == 5 || c == 6) ? 4'b0010 : 4'b0, 4'b0,
            (c == 5 || c == 6) ? 4'b0010 : 4'b0, 4'b0);

    // len=1 back-to-back: contiguous out 0..3
    len = 3'd1;
    for (int c = 0; c < 6; c++)
      cycle("b2b", c, (c == 0 || c == 2) ? 4'b0010 : 4'b0,
            (c <= 3) ? 4'b0010 : 4'b0,
            (c == 1 || c == 3) ? 4'b0010 : 4'b0,
            (c == 1 || c == 3) ? 4'b0010 : 4'b0, 4'b0);

    // retrig: spikes 0 and 2, len=3 -> out 0..5
    len    = 3'd3;
    retrig = 1'b1;
    for (int c = 0; c < 8; c++)
      cycle("retrig", c, (c == 0 || c == 2) ? 4'b0100 : 4'b0,
            (c <= 5) ? 4'b0100 : 4'b0,
            (c >= 1 && c <= 5) ? 4'b0100 : 4'b0,
            (c == 5) ? 4'b0100 : 4'b0, 4'b0);

    // retrig on the last cycle suppresses done and extends
    len = 3'd2;
    for (int c = 0; c < 6; c++)
      cycle("retrig_last", c, (c == 0 || c == 2) ? 4'b0001 : 4'b0,
            (c <= 4) ? 4'b0001 : 4'b0,
            (c >= 1 && c <= 4) ? 4'b0001 : 4'b0,
            (c == 4) ? 4'b0001 : 4'b0, 4'b0);

    // non-retrig: out 0..3, drop from 3, clr at 8 -> 0 at 9
    len    = 3'd3;
    retrig = 1'b0;
    for (int c = 0; c < 11; c++) begin
      clr_drop = (c == 8);
      cycle("noretrig", c, (c == 0 || c == 2) ? 4'b0100 : 4'b0,
            (c <= 3) ? 4'b0100 : 4'b0,
            (c >= 1 && c <= 3) ? 4'b0100 : 4'b0,
            (c == 3) ? 4'b0100 : 4'b0,
            (c >= 3 && c <= 8) ? 4'b0100 : 4'b0);
    end

    // drop set coinciding with clr_drop wins
    for (int c = 0; c < 6; c++) begin
      clr_drop = (c == 2 || c == 3);
      cycle("clr_vs_set", c, (c <= 2) ? 4'b0100 : 4'b0,
            (c <= 3) ? 4'b0100 : 4'b0,
            (c >= 1 && c <= 3) ? 4'b0100 : 4'b0,
            (c == 3) ? 4'b0100 : 4'b0,
            (c >= 2 && c <= 3) ? 4'b0100 : 4'b0);
    end
    clr_drop = 1'b0;

    // len change mid-pulse, then reset mid-pulse and fresh trigger
    for (int c = 0; c < 22; c++) begin
      len  = (c < 2) ? 3'd5 : (c < 10) ? 3'd1 : 3'd5;
      rstb = (c != 12);
      cycle("len_rst", c,
            (c == 0 || c == 10 || c == 14) ? 4'b1000 : 4'b0,
            (c <= 5 || c == 10 || c == 11 || (c >= 14 && c <= 19))
              ? 4'b1000 : 4'b0,
            ((c >= 1 && c <= 5) || c == 11 || (c >= 15 && c <= 19))
              ? 4'b1000 : 4'b0,
            (c == 5 || c == 19) ? 4'b1000 : 4'b0, 4'b0);
    end
    rstb = 1'b1;

    // all channels together, len=2
    len = 3'd2;
    for (int c = 0; c < 5; c++)
      cycle("allch", c, (c == 0) ? 4'b1111 : 4'b0,
            (c <= 2) ? 4'b1111 : 4'b0,
            (c >= 1 && c <= 2) ? 4'b1111 : 4'b0,
            (c == 2) ? 4'b1111 : 4'b0, 4'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_pulse_stretch.md
# spike_pulse_stretch

Multi-channel, runtime-configurable spike pulse stretcher for the temporal-coded neuron datapath. Each channel turns a 1-cycle spike from its parallel accumulate-compare stage into an output pulse of `len+1` cycles. Pulse length is programmable at run time. A mode input selects whether the block is retriggerable, and each channel reports a busy status, an end-of-pulse strobe and a sticky dropped-spike flag. It sits between the per-neuron compare outputs and the next layer's spike inputs.

## Interface
- `NCH`, default 4: number of independent channels.
- `WRES`, default 3: width of the length counter; maximum pulse is `2^WRES` cycles.
- `clk` input 1: unit clock for temporal encoding.
- `rstb` input 1: reset, synchronous, active-low.
- `in` input NCH: 1-cycle spike per channel.
- `len` input WRES: pulse length minus one.
- `retrig` input 1: 1 selects retriggerable mode, 0 selects non-retriggerable mode.
- `clr_drop` input 1: synchronous clear of all `drop` flags.
- `out` output NCH: stretched pulse per channel.
- `busy` output NCH: channel is in the ACTIVE state.
- `done` output NCH: high during the last high cycle of `out`.
- `drop` output NCH: sticky flag, set when a spike is ignored.

## Operation
- Each channel has 2 states, IDLE and ACTIVE, plus a WRES-bit down-counter `rem`.
- **IDLE behaviour:**
  - `out[i] = in[i]` combinationally.
  - If `in[i]=1` and `len!=0`: `rem <= len`, go to ACTIVE.
  - If `in[i]=1` and `len==0`: 1-cycle pulse, stay in IDLE, `done[i]=1` in that cycle.
- **ACTIVE behaviour:**
  - `out[i]=1`, `busy[i]=1`, `rem <= rem-1`.
  - When `rem==1`, `done[i]=1` and the next state is IDLE.
- **Spike while ACTIVE, `retrig=1`:** `rem <= len`, using the current `len`. The pulse then ends `len` cycles after the retrigger cycle. If `len==0` at that moment, the current cycle is the last one and `done[i]=1`.
- **Spike while ACTIVE, `retrig=0`:** the spike is ignored, `rem` keeps counting, and `drop[i] <= 1`.
- **Length latching:**
  - `len` is sampled only at trigger or retrigger.
  - Changing `len` mid-pulse does not alter a running pulse.
  - `retrig` is sampled every cycle.
- **Drop flag clearing:**
  - `clr_drop` clears all `drop` bits next cycle.
  - If a drop event coincides with `clr_drop`, set wins.
- **Channel independence:** channels share only `len`, `retrig`, `clr_drop`, `clk` and `rstb`. No arbitration between channels.
- **Width rules:**
  - `rem` is unsigned WRES bits and never wraps: it is only decremented when it is at least 1.
  - With `len = 2^WRES-1` the pulse is exactly `2^WRES` cycles.

## Timing
- **While `rstb=0`:**
  - State is IDLE, `rem=0`, `drop=0` on the next clock edge.
  - `out`, `busy` and `done` are forced to 0 combinationally.
- **Latency:** zero cycles. `out[i]` rises in the same cycle as the triggering `in[i]`.
- **Pulse extent:** a trigger at cycle t gives `out` high over t..t+len. `busy` is high over t+1..t+len. `done` is high at t+len.
- **Back-to-back pulses:** a spike in the cycle right after `done` starts a new pulse with no gap in `out` (contiguous high).
- **Reset mid-pulse:** `out` drops in the same cycle. The channel is IDLE after the edge, and no `done` is generated.
- **Spike together with `rem==1`:**
  - With `retrig=1`, the pulse is extended and `done` is suppressed.
  - With `retrig=0`, the spike is dropped and the pulse ends normally.

## Test plan
- **Basic stretch:** `WRES=3`, `len=7`, single spike on ch0 at cycle 10 -> `out[0]` high cycles 10..17, `done[0]` at 17, `busy[0]` 11..17, other channels stay 0.
- **Zero length:** `len=0`, spikes on ch1 at cycles 5 and 6 -> `out[1]` high at 5 and 6, `done[1]` at 5 and 6, `busy[1]` never high.
- **Retriggerable:** `len=3`, `retrig=1`, spikes on ch2 at 0 and 2 -> `out[2]` high 0..5, single `done` at 5, `drop[2]=0`.
- **Non-retriggerable:** same stimulus with `retrig=0` -> `out[2]` high 0..3, `done` at 3, `drop[2]=1` from cycle 3.
- **Drop flag clear:** assert `clr_drop` at cycle 8 -> `drop[2]=0` at 9. With a simultaneous drop event, `drop` stays 1.
- **Reset and `len` change mid-pulse:**
  - `len=5`, trigger ch3 at 0, change `len` to 1 at cycle 2 -> pulse still ends at 5.
  - Trigger again at 10 and assert `rstb=0` at 12 -> `out[3]` low from 12, no `done`, IDLE at 13, a fresh trigger at 14 behaves normally.
- **All channels together:** `NCH=4`, simultaneous spikes on all channels with `len=2` -> identical pulses 0..2 on every `out` bit.
